bus_gnrtr_n_rbtr: RTL and testbench
===================================

// Module: bus_gnrtr_n_rbtr
// PURPOSE
//  Shared-bus generator and arbiter connecting DRVRS bus-driver FIFOs.
//  Round-robin grants one driver with a pending packet, pops it from that driver's output FIFO,
//  and pushes it into the input FIFO of the driver addressed by the packet header.
//  Broadcast packets go to all drivers except the source.
//  Sits between the per-driver FIFO pairs and is the only path between them.
// PARAMETERS
//  bits      1            number of independent buses; one identical arbiter per bus index b
//  drvrs     4            number of drivers on each bus
//  pckg_sz   16           packet width; dest ID = pkt[pckg_sz-1 -: 8], payload = rest
//  broadcast {8{1'b1}}    dest ID meaning "all drivers except source"
// PORTS
//  clk     in   1                          single clock; all state on rising edge
//  reset   in   1                          asynchronous, active-low reset
//  pndng   in   [bits-1:0][drvrs-1:0]      driver d output FIFO non-empty
//  D_pop   in   [bits-1:0][drvrs-1:0][pckg_sz-1:0]  head-of-FIFO data of driver d
//  pop     out  [bits-1:0][drvrs-1:0]      1-cycle pulse: dequeue head of driver d
//  push    out  [bits-1:0][drvrs-1:0]      1-cycle pulse: enqueue D_push into driver d
//  D_push  out  [bits-1:0][drvrs-1:0][pckg_sz-1:0]  packet on bus; all d lanes of a bus carry the same value
// BEHAVIOUR
//  Reset (reset=0, async): pop=0, push=0, D_push=0, state=IDLE, rr_last=drvrs-1 (driver 0 wins first).
//  Reset mid-operation: outputs clear immediately; an in-flight packet is lost.
//  FSM per bus: IDLE -> GRANT -> SEND -> IDLE. One packet per 3 cycles max.
//  IDLE, at a rising edge with any pndng[b] set:
//   - winner w = first set bit searching rr_last+1, rr_last+2, ... modulo drvrs.
//   - pkt <= D_pop[b][w]; pop[b][w] <= 1; rr_last <= w; go to GRANT.
//  No pndng set in IDLE: stay in IDLE, all outputs 0.
//  GRANT (1 cycle, pop[b][w]=1 visible): at the edge, pop <= 0.
//   - D_push[b][*] <= pkt.
//   - dest = pkt[pckg_sz-1 -: 8].
//   - dest == broadcast: push[b][d] <= 1 for every d != w.
//   - dest < drvrs: push[b][dest] <= 1, including dest == w.
//   - Any other dest: no push; the packet is dropped.
//   - Go to SEND.
//  SEND (1 cycle, push visible with D_push=pkt): at the edge, push <= 0 and go to IDLE.
//   - D_push holds pkt until the next GRANT overwrites it.
//  pndng sampled only in IDLE; changes in other states are ignored.
//  pop never asserted to more than one driver at a time; pop never asserted while pndng=0.
//  Latency: pndng seen at edge k -> pop high in cycle k..k+1 -> push high in cycle k+1..k+2.
//  Buses b are fully independent; no shared state across b.
// TESTING (drvrs=8, pckg_sz=16)
//  1. Hold reset=0 with random pndng/D_pop -> pop, push and D_push all 0; release -> first grant goes to lowest pending id.
//  2. pndng[0][2]=1, D_pop[0][2]=16'h05AB -> pop[0][2] one cycle; next cycle push[0][5]=1 only, D_push=16'h05AB.
//  3. Driver 3 sends 16'hFF12 -> push[0] = 8'b1111_0111 for one cycle, D_push=16'hFF12.
//  4. pndng on drivers 1, 4, 6 held high -> pop order 1, 4, 6, 1, 4; new pop every 3 cycles.
//  5. Driver 0 sends 16'h0A00 (dest 10 >= drvrs) -> pop[0][0] pulses; no push for that packet.
//  6. Assert reset=0 while in SEND -> push drops to 0 without a clock edge; after release, state is IDLE and rr_last=7.

Source files
------------

// File: rtl/bus_gnrtr_n_rbtr.sv
// rtl/bus_gnrtr_n_rbtr.sv - round-robin shared-bus arbiter moving packets between driver FIFOs
// One independent IDLE->GRANT->SEND engine per bus index.
module bus_gnrtr_n_rbtr #(
  parameter int          bits      = 1,
  parameter int          drvrs     = 4,
  parameter int          pckg_sz   = 16,
  parameter logic [7:0]  broadcast = {8{1'b1}}
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic [bits-1:0][drvrs-1:0]                   pndng,
  input  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0]      D_pop,
  output logic [bits-1:0][drvrs-1:0]                   pop,
  output logic [bits-1:0][drvrs-1:0]                   push,
  output logic [bits-1:0][drvrs-1:0][pckg_sz-1:0]      D_push
);

  localparam int IW = (drvrs > 1) ? $clog2(drvrs) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, SEND} state_t;

  for (genvar b = 0; b < bits; b++) begin : g_bus
    state_t             state_d, state_q;
    logic [IW-1:0]      rr_last_d, rr_last_q;
    logic [pckg_sz-1:0] pkt_d, pkt_q;
    logic [pckg_sz-1:0] dpush_d, dpush_q;
    logic [drvrs-1:0]   pop_d, pop_q;
    logic [drvrs-1:0]   push_d, push_q;
    logic               found;
    logic [IW-1:0]      win;
    logic [7:0]         dest;
    int                 idx;

    always_comb begin
      state_d   = state_q;
      rr_last_d = rr_last_q;
      pkt_d     = pkt_q;
      dpush_d   = dpush_q;
      pop_d     = '0;
      push_d    = '0;
      found     = 1'b0;
      win       = '0;
      idx       = 0;
      dest      = pkt_q[pckg_sz-1 -: 8];

      // Search starts just after the last winner so every driver gets a turn.
      for (int i = 1; i <= drvrs; i++) begin
        idx = (int'(rr_last_q) + i) % drvrs;
        if (!found && pndng[b][idx]) begin
          found = 1'b1;
          win   = IW'(idx);
        end
      end

      case (state_q)
        IDLE: begin
          if (found) begin
            pkt_d       = D_pop[b][win];
            pop_d[win]  = 1'b1;
            rr_last_d   = win;
            state_d     = GRANT;
          end
        end
        GRANT: begin
          dpush_d = pkt_q;
          if (dest == broadcast) begin
            push_d            = '1;
            push_d[rr_last_q] = 1'b0;
          end else if (int'(dest) < drvrs) begin
            push_d[dest[IW-1:0]] = 1'b1;
          end
          state_d = SEND;
        end
        SEND:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state_q   <= IDLE;
        rr_last_q <= IW'(drvrs - 1);
        pkt_q     <= '0;
        dpush_q   <= '0;
        pop_q     <= '0;
        push_q    <= '0;
      end else begin
        state_q   <= state_d;
        rr_last_q <= rr_last_d;
        pkt_q     <= pkt_d;
        dpush_q   <= dpush_d;
        pop_q     <= pop_d;
        push_q    <= push_d;
      end
    end

    assign pop[b]  = pop_q;
    assign push[b] = push_q;
    for (genvar d = 0; d < drvrs; d++) begin : g_lane
      assign D_push[b][d] = dpush_q;
    end
  end

endmodule

// File: tb/tb_bus_gnrtr_n_rbtr.sv
// tb/tb_bus_gnrtr_n_rbtr.sv - randomized and directed checks of bus_gnrtr_n_rbtr against a packet-level model
module tb_bus_gnrtr_n_rbtr;

  localparam int ND = 8;
  localparam int PW = 16;

  logic                          clk = 1'b0;
  logic                          reset;
  logic [0:0][ND-1:0]            pndng;
  logic [0:0][ND-1:0][PW-1:0]    D_pop;
  logic [0:0][ND-1:0]            pop;
  logic [0:0][ND-1:0]            push;
  logic [0:0][ND-1:0][PW-1:0]    D_push;

  bus_gnrtr_n_rbtr #(.bits(1), .drvrs(ND), .pckg_sz(PW)) dut (
    .clk    (clk),
    .reset  (reset),
    .pndng  (pndng),
    .D_pop  (D_pop),
    .pop    (pop),
    .push   (push),
    .D_push (D_push)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: which packet is in flight and how far along the 3-cycle transfer it is.
  int          m_rr;
  int          m_phase;
  int          m_w;
  logic [15:0] m_pkt;
  logic [7:0]  exp_pop, exp_push;
  logic [15:0] exp_dpush;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_rr = ND - 1; m_phase = 0; m_w = 0; m_pkt = '0;
    exp_pop = '0; exp_push = '0; exp_dpush = '0;
  endtask

  task automatic model_edge();
    int dest;
    bit hit;
    exp_pop  = '0;
    exp_push = '0;
    if (m_phase == 0) begin
      hit = 0;
      for (int k = 1; k <= ND; k++) begin
        if (!hit && pndng[0][(m_rr + k) % ND]) begin
          hit = 1;
          m_w = (m_rr + k) % ND;
        end
      end
      if (hit) begin
        m_pkt   = D_pop[0][m_w];
        exp_pop = 8'(1 << m_w);
        m_rr    = m_w;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      exp_dpush = m_pkt;
      dest = int'(m_pkt[15:8]);
      if (dest == 255)   exp_push = 8'hFF & ~8'(1 << m_w);
      else if (dest < ND) exp_push = 8'(1 << dest);
      m_phase = 2;
    end else begin
      m_phase = 0;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!reset) model_reset(); else model_edge();
    @(negedge clk);
    chk("pop", 32'(pop[0]), 32'(exp_pop));
    chk("push", 32'(push[0]), 32'(exp_push));
    for (int d = 0; d < ND; d++) chk("d_push", 32'(D_push[0][d]), 32'(exp_dpush));
  endtask

  function automatic logic [15:0] rand_pkt();
    int sel = $urandom_range(0, 9);
    logic [7:0] dest;
    if (sel < 6)      dest = 8'($urandom_range(0, ND - 1));
    else if (sel < 8) dest = 8'hFF;
    else              dest = 8'($urandom_range(ND, 254));
    return {dest, 8'($urandom)};
  endfunction

  task automatic rand_inputs();
    for (int d = 0; d < ND; d++) begin
      pndng[0][d] = ($urandom_range(0, 9) < 4);
      D_pop[0][d] = rand_pkt();
    end
  endtask

  task automatic idle_cycles(input int n);
    pndng = '0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int order [5] = '{1, 4, 6, 1, 4};
    logic [7:0] p;
    reset = 1'b0;
    pndng = '0;
    D_pop = '0;
    model_reset();

    // Held in reset: nothing moves regardless of inputs.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      rand_inputs();
      pndng[0][$urandom_range(0, ND - 1)] = 1'b1;
      cycle();
    end
    @(negedge clk);
    reset = 1'b1;
    rand_inputs();
    pndng[0][$urandom_range(0, ND - 1)] = 1'b1;
    p = pndng[0];
    cycle();
    chk("first_grant_lowest", 32'(pop[0]), 32'(p & (~p + 8'd1)));
    idle_cycles(3);

    // Unicast from driver 2 to driver 5.
    pndng[0][2] = 1'b1; D_pop[0][2] = 16'h05AB;
    cycle();
    chk("t2_pop", 32'(pop[0]), 32'h04);
    pndng = '0;
    cycle();
    chk("t2_push", 32'(push[0]), 32'h20);
    chk("t2_data", 32'(D_push[0][0]), 32'h05AB);
    idle_cycles(3);

    // Broadcast from driver 3.
    pndng[0][3] = 1'b1; D_pop[0][3] = 16'hFF12;
    cycle();
    pndng = '0;
    cycle();
    chk("t3_push", 32'(push[0]), 32'hF7);
    chk("t3_data", 32'(D_push[0][7]), 32'hFF12);
    cycle();
    chk("t3_push_off", 32'(push[0]), 32'h00);
    idle_cycles(2);

    // Undeliverable destination from driver 0.
    pndng[0][0] = 1'b1; D_pop[0][0] = 16'h0A00;
    cycle();
    chk("t5_pop", 32'(pop[0]), 32'h01);
    pndng = '0;
    cycle();
    chk("t5_push", 32'(push[0]), 32'h00);
    idle_cycles(3);

    // Round-robin among 1, 4, 6 held pending.
    pndng[0] = 8'b0101_0010;
    for (int d = 0; d < ND; d++) D_pop[0][d] = rand_pkt();
    for (int i = 0; i < 15; i++) begin
      cycle();
      if (i % 3 == 0) chk("t4_order", 32'(pop[0]), 32'(1 << order[i / 3]));
      else            chk("t4_gap", 32'(pop[0]), 32'h00);
    end
    idle_cycles(3);

    // Asynchronous reset while push is visible.
    pndng[0][2] = 1'b1; D_pop[0][2] = 16'h0100;
    cycle();
    pndng = '0;
    cycle();
    chk("t6_pre_push", 32'(push[0]), 32'h02);
    reset = 1'b0;
    #1;
    model_reset();
    chk("t6_async_push", 32'(push[0]), 32'h00);
    chk("t6_async_dpush", 32'(D_push[0][0]), 32'h0000);
    cycle();
    @(negedge clk);
    reset = 1'b1;
    pndng[0] = 8'hFF;
    cycle();
    chk("t6_rr_restart", 32'(pop[0]), 32'h01);
    idle_cycles(3);

    // Randomized traffic with occasional reset pulses.
    for (int i = 0; i < 1500; i++) begin
      rand_inputs();
      reset = ($urandom_range(0, 199) != 0);
      cycle();
    end
    reset = 1'b1;
    idle_cycles(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
